// File: rtl/pixel_sequentializer.sv
// Burst-to-pixel serializer: unpacks wide frame-grabber beats into one pixel per cycle,
// tagging each pixel with row/column coordinates and ap_* frame control.
module pixel_sequentializer #(
    parameter int PIXEL_BIT_WIDTH  = 8,
    parameter int PIXELS_PER_BURST = 8,
    parameter int IN_ROWS          = 4,
    parameter int IN_COLS          = 16
) (
    input  logic                                         clk,
    input  logic                                         s_axis_resetn,
    input  logic                                         ap_start,
    output logic                                         ap_done,
    output logic                                         ap_ready,
    output logic                                         ap_idle,
    input  logic                                         s_axis_tvalid,
    output logic                                         s_axis_tready,
    input  logic [PIXELS_PER_BURST*PIXEL_BIT_WIDTH-1:0]  s_axis_tdata,
    input  logic                                         s_axis_tuser,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]                   m_axis_tdata,
    output logic                                         m_axis_tlast,
    output logic [$clog2(IN_COLS)-1:0]                   cnt_col,
    output logic [$clog2(IN_ROWS)-1:0]                   cnt_row,
    output logic                                         frame_err
);
    localparam int COL_W = $clog2(IN_COLS);
    localparam int ROW_W = $clog2(IN_ROWS);
    localparam int K_W   = (PIXELS_PER_BURST > 1) ? $clog2(PIXELS_PER_BURST) : 1;

    if (IN_COLS % PIXELS_PER_BURST != 0) begin : g_bad_cols
        $error("IN_COLS must be a multiple of PIXELS_PER_BURST");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                                      r_state;
    state_t                                      w_state_next;
    logic [PIXELS_PER_BURST*PIXEL_BIT_WIDTH-1:0] r_buf;
    logic [K_W-1:0]                              r_k;
    logic                                        r_full;
    logic [COL_W-1:0]                            r_col;
    logic [ROW_W-1:0]                            r_row;
    logic                                        r_frame_err;

    logic w_run;
    logic w_out_hs;
    logic w_last_k;
    logic w_last_col;
    logic w_last_row;
    logic w_last_pix;
    logic w_in_ready;
    logic w_in_hs;
    logic w_resync;
    logic w_final;

    assign w_run      = (r_state == S_RUN);
    assign w_out_hs   = m_axis_tvalid && m_axis_tready;
    assign w_last_k   = (r_k == K_W'(PIXELS_PER_BURST - 1));
    assign w_last_col = (r_col == COL_W'(IN_COLS - 1));
    assign w_last_row = (r_row == ROW_W'(IN_ROWS - 1));
    assign w_last_pix = w_last_col && w_last_row;
    // Refill in the same cycle the last buffered pixel leaves, except at end of frame.
    assign w_in_ready = w_run && (!r_full || (w_last_k && w_out_hs && !w_last_pix));
    assign w_in_hs    = s_axis_tvalid && w_in_ready;
    assign w_resync   = w_in_hs && s_axis_tuser && ((r_col != '0) || (r_row != '0) || r_full);
    assign w_final    = w_out_hs && w_last_pix;

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (ap_start) w_state_next = S_RUN;
            S_RUN:   if (w_final) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            // NOTE: the pixel buffer is reset too, so m_axis_tdata reads 0 out of reset.
            r_buf       <= '0;
            r_k         <= '0;
            r_full      <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && ap_start) begin
                r_frame_err <= 1'b0;
            end else if (w_resync) begin
                r_frame_err <= 1'b1;
            end

            if (w_resync) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_out_hs) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_in_hs) begin
                r_buf  <= s_axis_tdata;
                r_k    <= '0;
                r_full <= 1'b1;
            end else if (w_out_hs) begin
                if (w_last_k) begin
                    r_k    <= '0;
                    r_full <= 1'b0;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    assign ap_ready      = (r_state == S_IDLE);
    assign ap_idle       = (r_state == S_IDLE);
    assign ap_done       = (r_state == S_DONE);
    assign s_axis_tready = w_in_ready;
    assign m_axis_tvalid = w_run && r_full;
    assign m_axis_tdata  = r_buf[r_k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
    assign m_axis_tlast  = m_axis_tvalid && w_last_pix;
    assign cnt_col       = r_col;
    assign cnt_row       = r_row;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_pixel_sequentializer.sv
// Scoreboard bench for pixel_sequentializer: a table of frame scenarios plus hand-written
// reset and back-to-back sequences; beats accepted push expected pixels, output handshakes pop them.
module tb_pixel_sequentializer;
    localparam int W     = 8;
    localparam int PPB   = 8;
    localparam int ROWS  = 4;
    localparam int COLS  = 16;
    localparam int COL_W = 4;
    localparam int ROW_W = 2;
    localparam int NPIX  = ROWS * COLS;
    localparam int NBEAT = NPIX / PPB;

    logic               clk = 1'b0;
    logic               s_axis_resetn = 1'b0;
    logic               ap_start = 1'b0;
    logic               ap_done, ap_ready, ap_idle;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tready;
    logic [PPB*W-1:0]   s_axis_tdata = '0;
    logic               s_axis_tuser = 1'b0;
    logic               m_axis_tvalid;
    logic               m_axis_tready = 1'b0;
    logic [W-1:0]       m_axis_tdata;
    logic               m_axis_tlast;
    logic [COL_W-1:0]   cnt_col;
    logic [ROW_W-1:0]   cnt_row;
    logic               frame_err;

    pixel_sequentializer #(
        .PIXEL_BIT_WIDTH (W),
        .PIXELS_PER_BURST(PPB),
        .IN_ROWS         (ROWS),
        .IN_COLS         (COLS)
    ) dut (
        .clk          (clk),
        .s_axis_resetn(s_axis_resetn),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_ready     (ap_ready),
        .ap_idle      (ap_idle),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .cnt_col      (cnt_col),
        .cnt_row      (cnt_row),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PPB*W-1:0] data;
        logic             user;
    } beat_t;

    // Inputs (ready_pct..reset_at) and expected results (exp_*) of one frame scenario.
    typedef struct {
        int ready_pct;
        int gaps;
        int start_at;
        int sof_inject;
        int reset_at;
        int exp_pix;
        int exp_done;
        int exp_err;
    } vec_t;

    beat_t        in_q[$];
    logic [W-1:0] exp_q[$];
    int           n_pass = 0;
    int           n_total = 0;
    int           n_out, n_done, pos, cyc, gap_idle;
    bit           hold_pending, last_prev;
    logic [15:0]  hold_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_reset(input string name);
        check(name,
              {ap_done, ap_ready, ap_idle, s_axis_tready, m_axis_tvalid, m_axis_tdata,
               m_axis_tlast, cnt_col, cnt_row, frame_err},
              {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 2'h0, 1'b0});
    endtask

    function automatic beat_t make_beat(input int b, input bit user);
        beat_t r;
        for (int k = 0; k < PPB; k++) r.data[k*W +: W] = W'(b * PPB + k);
        r.user = user;
        return r;
    endfunction

    // One clock: drive at negedge, evaluate handshakes 1 ns later, the following posedge commits.
    task automatic cycle(input int ready_pct, input int gaps, input bit start);
        logic [W-1:0]     exp_px;
        logic [COL_W-1:0] ec;
        logic [ROW_W-1:0] er;
        beat_t            b;
        @(negedge clk);
        ap_start      = start;
        s_axis_tvalid = (in_q.size() > 0) && ((gaps == 0) || ($urandom_range(1, 0) == 1));
        if (in_q.size() > 0) begin
            s_axis_tdata = in_q[0].data;
            s_axis_tuser = in_q[0].user;
        end else begin
            s_axis_tdata = '0;
            s_axis_tuser = 1'b0;
        end
        m_axis_tready = ($urandom_range(99, 0) < ready_pct);
        #1;
        cyc++;
        if (ap_idle && n_done == 1) gap_idle++;
        if (hold_pending)
            check("axis_hold", {m_axis_tvalid, m_axis_tdata, cnt_row, cnt_col, m_axis_tlast}, hold_val);
        if (ap_done || last_prev) check("done_latency", 32'(ap_done), 32'(last_prev));
        if (ap_done) n_done++;
        last_prev = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", {m_axis_tdata, cnt_row, cnt_col}, 32'hFFFF_FFFF);
            end else begin
                exp_px = exp_q.pop_front();
                ec = COL_W'(pos % COLS);
                er = ROW_W'(pos / COLS);
                check("pixel_data_row_col_last", {m_axis_tdata, cnt_row, cnt_col, m_axis_tlast},
                      {exp_px, er, ec, (pos == NPIX - 1)});
            end
            last_prev = (pos == NPIX - 1);
            pos = (pos == NPIX - 1) ? 0 : pos + 1;
            n_out++;
        end
        hold_pending = m_axis_tvalid && !m_axis_tready;
        hold_val     = {1'b1, m_axis_tdata, cnt_row, cnt_col, m_axis_tlast};
        if (s_axis_tvalid && s_axis_tready) begin
            b = in_q.pop_front();
            if (b.user && (pos != 0 || exp_q.size() != 0)) begin
                exp_q.delete();
                pos = 0;
            end
            for (int k = 0; k < PPB; k++) exp_q.push_back(b.data[k*W +: W]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_axis_resetn = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        ap_start      = 1'b0;
        #1;
        check_reset("reset_midframe_outputs");
        in_q.delete();
        exp_q.delete();
        pos          = 0;
        hold_pending = 1'b0;
        last_prev    = 1'b0;
        @(negedge clk);
        s_axis_resetn = 1'b1;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int budget;
        bit pulsed, was_reset, start;
        if (v.sof_inject != 0)
            for (int b = 0; b < 3; b++) in_q.push_back(make_beat(b, b == 0));
        for (int b = 0; b < NBEAT; b++) in_q.push_back(make_beat(b, b == 0));
        n_out = 0;
        n_done = 0;
        pulsed = 1'b0;
        was_reset = 1'b0;
        cycle(100, 0, 1'b0);
        check($sformatf("v%0d_idle_stall", idx),
              {ap_idle, ap_ready, s_axis_tready, m_axis_tvalid}, 4'b1100);
        cycle(100, 0, 1'b1);
        budget = 3000;
        while (n_done == 0 && budget > 0 && !was_reset) begin
            start = 1'b0;
            if (v.start_at >= 0 && !pulsed && n_out == v.start_at) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (v.reset_at >= 0 && n_out == v.reset_at) begin
                do_reset();
                was_reset = 1'b1;
            end else begin
                cycle(v.ready_pct, v.gaps, start);
            end
            budget--;
        end
        cycle(100, 0, 1'b0);
        cycle(100, 0, 1'b0);
        check($sformatf("v%0d_done_count", idx), n_done, v.exp_done);
        check($sformatf("v%0d_pixel_count", idx), n_out, v.exp_pix);
        check($sformatf("v%0d_frame_err", idx), 32'(frame_err), v.exp_err);
        check($sformatf("v%0d_idle_after", idx), {ap_idle, ap_ready, m_axis_tvalid}, 3'b110);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{100, 0, -1, 0, -1, 64, 1, 0};  // plain frame, full throughput
        vecs[1] = '{50,  1, -1, 0, -1, 64, 1, 0};  // random backpressure and input gaps
        vecs[2] = '{100, 0, 20, 0, -1, 64, 1, 0};  // ap_start pulsed at pixel 20
        vecs[3] = '{100, 0, -1, 1, -1, 88, 1, 1};  // SOF resync after 3 beats
        vecs[4] = '{70,  1, -1, 0, -1, 64, 1, 0};  // next ap_start clears frame_err
        vecs[5] = '{100, 0, -1, 0, 30, 30, 0, 0};  // reset at pixel 30
        vecs[6] = '{100, 0, -1, 0, -1, 64, 1, 0};  // clean frame after reset

        cyc = 0;
        pos = 0;
        gap_idle = 0;
        hold_pending = 1'b0;
        last_prev = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset("power_on_reset_outputs");
        s_axis_resetn = 1'b1;

        for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

        // Two frames with ap_start held high: one DONE cycle and one IDLE cycle between them.
        for (int b = 0; b < 2 * NBEAT; b++) in_q.push_back(make_beat(b % NBEAT, (b % NBEAT) == 0));
        n_out = 0;
        n_done = 0;
        gap_idle = 0;
        for (int t = 0; t < 2000 && n_done < 2; t++) cycle(100, 0, 1'b1);
        cycle(100, 0, 1'b0);
        cycle(100, 0, 1'b0);
        check("b2b_done_pulses", n_done, 2);
        check("b2b_pixel_count", n_out, 2 * NPIX);
        check("b2b_idle_gap", gap_idle, 1);
        check("b2b_frame_err", 32'(frame_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
